// File: rtl/xm_pipe_stage_pkg.sv
// Shared Execute->Memory definitions: control bundle and default-width types.
// Imported by xm_pipe_stage and xm_fwd_mux.
package xm_pipe_stage_pkg;

  localparam int CTRL_W = 6;

  typedef struct packed {
    logic reg_write;
    logic read_mem;
    logic write_mem;
    logic mem_to_reg;
    logic branch;
    logic jmp;
  } xm_ctrl_t;

  typedef logic [31:0] program_counter_t;
  typedef logic [4:0]  reg_addr_t;

  function automatic int sel_w(input int srcs);
    return $clog2(srcs + 1);
  endfunction

endpackage

// File: rtl/xm_fwd_mux.sv
// N-source store-data forwarding select.
// sel=0 or sel>FWD_SRCS returns dflt; sel=k returns srcs slice k-1.
module xm_fwd_mux
  import xm_pipe_stage_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int FWD_SRCS = 2,
  parameter int SEL_W    = sel_w(FWD_SRCS)
) (
  input  logic [SEL_W-1:0]           sel,
  input  logic [DATA_W-1:0]          dflt,
  input  logic [FWD_SRCS*DATA_W-1:0] srcs,
  output logic [DATA_W-1:0]          y
);

  always_comb begin
    y = dflt;
    for (int k = 0; k < FWD_SRCS; k++) begin
      if (sel == SEL_W'(k + 1)) begin
        y = srcs[k*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/xm_pipe_stage.sv
// Execute->Memory pipeline register with stall, flush and store-data forwarding.
// Define XM_SKID_EN for a one-entry skid buffer with registered in_ready.
module xm_pipe_stage
  import xm_pipe_stage_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int PC_W     = 32,
  parameter int RADDR_W  = 5,
  parameter int FWD_SRCS = 2,
  parameter int CNT_W    = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CTRL_W-1:0]          in_ctrl,
  input  logic [PC_W-1:0]            in_pc,
  input  logic                       in_alu_zero,
  input  logic [DATA_W-1:0]          in_alu_out,
  input  logic [DATA_W-1:0]          in_write_d,
  input  logic [RADDR_W-1:0]         in_rd_a,
  input  logic [$clog2(FWD_SRCS+1)-1:0] fwd_sel,
  input  logic [FWD_SRCS*DATA_W-1:0] fwd_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CTRL_W-1:0]          out_ctrl,
  output logic [PC_W-1:0]            out_pc,
  output logic                       out_alu_zero,
  output logic [DATA_W-1:0]          out_alu_out,
  output logic [DATA_W-1:0]          out_write_d,
  output logic [RADDR_W-1:0]         out_rd_a,
  output logic [CNT_W-1:0]           stall_cnt
);

  localparam int BEAT_W =
    CTRL_W + PC_W + 1 + 2 * DATA_W + RADDR_W;

  logic [DATA_W-1:0] fwd_wd;
  logic [BEAT_W-1:0] in_beat;
  logic [BEAT_W-1:0] out_beat;
  xm_ctrl_t          ctrl_q;
  logic              accept;
  logic              stalled;

  xm_fwd_mux #(
    .DATA_W  (DATA_W),
    .FWD_SRCS(FWD_SRCS)
  ) u_fwd (
    .sel (fwd_sel),
    .dflt(in_write_d),
    .srcs(fwd_data),
    .y   (fwd_wd)
  );

  assign in_beat = {in_ctrl, in_pc, in_alu_zero,
                    in_alu_out, fwd_wd, in_rd_a};
  assign accept  = in_valid && in_ready;
  assign stalled = out_valid && !out_ready;

`ifdef XM_SKID_EN
  logic              skid_full;
  logic [BEAT_W-1:0] skid_beat;

  assign in_ready = !skid_full;

  // Skid drains ahead of new input; no accept while it is full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_beat  <= '0;
      skid_full <= 1'b0;
      skid_beat <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      skid_full <= 1'b0;
    end else if (!stalled) begin
      if (skid_full) begin
        out_beat  <= skid_beat;
        out_valid <= 1'b1;
        skid_full <= 1'b0;
      end else if (accept) begin
        out_beat  <= in_beat;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_beat <= in_beat;
      skid_full <= 1'b1;
    end
  end
`else
  assign in_ready = out_ready || !out_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_beat  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_beat  <= in_beat;
      out_valid <= 1'b1;
    end else if (!stalled) begin
      out_valid <= 1'b0;
    end
  end
`endif

  assign {ctrl_q, out_pc, out_alu_zero,
          out_alu_out, out_write_d, out_rd_a} = out_beat;

  // A bubble must never write regs or memory.
  assign out_ctrl = out_valid ? ctrl_q : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stalled && !flush && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_xm_pipe_stage.sv
// Randomized and directed bench for xm_pipe_stage against a beat-queue model.
// Honours XM_SKID_EN when defined for the build.
module tb_xm_pipe_stage;

  localparam int DW = 32;
  localparam int PW = 32;
  localparam int RW = 5;
  localparam int NS = 2;
  localparam int CW = 4;
  localparam int SW = $clog2(NS + 1);
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 0;
  logic          rst = 1;
  logic          flush = 0;
  logic          in_valid = 0;
  logic          in_ready;
  logic [5:0]    in_ctrl = 0;
  logic [PW-1:0] in_pc = 0;
  logic          in_alu_zero = 0;
  logic [DW-1:0] in_alu_out = 0;
  logic [DW-1:0] in_write_d = 0;
  logic [RW-1:0] in_rd_a = 0;
  logic [SW-1:0] fwd_sel = 0;
  logic [NS*DW-1:0] fwd_data = 0;
  logic          out_valid;
  logic          out_ready = 1;
  logic [5:0]    out_ctrl;
  logic [PW-1:0] out_pc;
  logic          out_alu_zero;
  logic [DW-1:0] out_alu_out;
  logic [DW-1:0] out_write_d;
  logic [RW-1:0] out_rd_a;
  logic [CW-1:0] stall_cnt;

  xm_pipe_stage #(
    .DATA_W(DW), .PC_W(PW), .RADDR_W(RW),
    .FWD_SRCS(NS), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_pc(in_pc),
    .in_alu_zero(in_alu_zero),
    .in_alu_out(in_alu_out),
    .in_write_d(in_write_d), .in_rd_a(in_rd_a),
    .fwd_sel(fwd_sel), .fwd_data(fwd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_pc(out_pc),
    .out_alu_zero(out_alu_zero),
    .out_alu_out(out_alu_out),
    .out_write_d(out_write_d),
    .out_rd_a(out_rd_a), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]    ctrl;
    logic [PW-1:0] pc;
    logic          z;
    logic [DW-1:0] alu;
    logic [DW-1:0] wd;
    logic [RW-1:0] rd;
  } beat_t;

  int checks = 0;
  int errors = 0;
  beat_t q[$];
  int m_cnt = 0;
  int m_acc = 0;
  int dut_acc = 0;
  int writes = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h",
               name, act, exp);
    end
  endtask

  function automatic logic m_ready();
`ifdef XM_SKID_EN
    return q.size() < 2;
`else
    return q.size() == 0 || out_ready;
`endif
  endfunction

  function automatic logic [DW-1:0] exp_wd();
    if (fwd_sel == 0 || int'(fwd_sel) > NS) return in_write_d;
    return fwd_data[(int'(fwd_sel) - 1) * DW +: DW];
  endfunction

  // Model: ordered list of beats in flight, head is on the output.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_cnt = 0;
    end else begin
      logic acc;
      beat_t b;
      acc = in_valid && m_ready();
      if (!flush && q.size() > 0 && !out_ready && m_cnt < CMAX)
        m_cnt++;
      if (flush) begin
        q.delete();
      end else begin
        if (q.size() > 0 && out_ready) void'(q.pop_front());
        if (acc) begin
          b = '{in_ctrl, in_pc, in_alu_zero,
                in_alu_out, exp_wd(), in_rd_a};
          q.push_back(b);
          m_acc++;
        end
      end
    end
  end

  always @(negedge clk) begin
    beat_t d;
    d = '{out_ctrl, out_pc, out_alu_zero,
          out_alu_out, out_write_d, out_rd_a};
    chk("in_ready", 64'(in_ready), 64'(m_ready()));
    chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
    chk("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
    if (q.size() > 0) begin
      if (d !== q[0]) begin
        checks++;
        errors++;
        $display("FAIL beat actual=%0h expected=%0h", d, q[0]);
      end else checks++;
    end else begin
      chk("bubble_ctrl", 64'(out_ctrl), 64'(0));
    end
    if (!rst && in_valid && in_ready) dut_acc++;
    if (!rst && out_valid && out_ready && out_ctrl[3]) writes++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    in_valid = 0;
    flush = 0;
    tick();
    rst = 0;
  endtask

  task automatic drive(input logic [5:0] c,
                       input logic [DW-1:0] a,
                       input logic [RW-1:0] r);
    in_valid = 1;
    in_ctrl = c;
    in_alu_out = a;
    in_rd_a = r;
    in_pc = $urandom;
    in_alu_zero = (a == 0);
    in_write_d = $urandom;
    fwd_sel = 0;
  endtask

  initial begin
    logic [DW-1:0] fexp [4];
    int start;
    int cyc;
    fexp[0] = 32'hAAAA; fexp[1] = 32'h1111;
    fexp[2] = 32'h2222; fexp[3] = 32'hAAAA;

    tick();
    tick();
    rst = 0;
    chk("rst_valid", 64'(out_valid), 0);
    chk("rst_ctrl", 64'(out_ctrl), 0);
    chk("rst_pc", 64'(out_pc), 0);
    chk("rst_alu", 64'(out_alu_out), 0);
    chk("rst_wd", 64'(out_write_d), 0);
    chk("rst_rd", 64'(out_rd_a), 0);
    chk("rst_cnt", 64'(stall_cnt), 0);

    out_ready = 1;
    drive(6'b100000, 32'h1234, 5'd7);
    tick();
    in_valid = 0;
    chk("b1_valid", 64'(out_valid), 1);
    chk("b1_alu", 64'(out_alu_out), 64'h1234);
    chk("b1_rd", 64'(out_rd_a), 7);
    chk("b1_ctrl", 64'(out_ctrl), 64'h20);
    tick();
    chk("b1_done_valid", 64'(out_valid), 0);
    chk("b1_done_ctrl", 64'(out_ctrl), 0);

    for (int s = 0; s < 4; s++) begin
      drive(6'b001000, 32'h55, 5'd3);
      in_write_d = 32'hAAAA;
      fwd_data = {32'h2222, 32'h1111};
      fwd_sel = SW'(s);
      tick();
      chk($sformatf("fwd_sel%0d", s),
          64'(out_write_d), 64'(fexp[s]));
    end
    in_valid = 0;
    tick();

    do_reset();
    out_ready = 0;
    drive(6'b001000, 32'hA5A5, 5'd9);
    tick();
    drive(6'b100000, 32'hBBBB, 5'd4);
    repeat (5) tick();
    chk("stall_cnt5", 64'(stall_cnt), 5);
    chk("stall_alu", 64'(out_alu_out), 64'hA5A5);
    chk("stall_valid", 64'(out_valid), 1);
    chk("stall_ready", 64'(in_ready), 0);
    in_valid = 0;
    flush = 1;
    tick();
    flush = 0;
    chk("flush_valid", 64'(out_valid), 0);
    chk("flush_ctrl", 64'(out_ctrl), 0);
    chk("flush_cnt", 64'(stall_cnt), 5);
    writes = 0;
    out_ready = 1;
    repeat (3) tick();
    chk("flush_nowrite", 64'(writes), 0);
    chk("flush_empty", 64'(out_valid), 0);

    do_reset();
    out_ready = 0;
    drive(6'b000001, 32'h77, 5'd1);
    tick();
    in_valid = 0;
    repeat (20) tick();
    chk("sat_cnt", 64'(stall_cnt), 15);
    out_ready = 1;
    tick();
    tick();

    start = dut_acc;
    for (int i = 0; i < 10; i++) begin
      drive(6'(i), DW'(i + 100), RW'(i));
      tick();
    end
    in_valid = 0;
    tick();
    chk("full_rate", 64'(dut_acc - start), 10);

    start = m_acc;
    cyc = 0;
    while (m_acc - start < 100 && cyc < 3000) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_ctrl = 6'($urandom);
      in_pc = $urandom;
      in_alu_zero = 1'($urandom);
      in_alu_out = $urandom;
      in_write_d = $urandom;
      in_rd_a = 5'($urandom);
      fwd_sel = SW'($urandom);
      fwd_data = {$urandom, $urandom};
      out_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 31) == 0);
      tick();
      cyc++;
    end
    chk("stream_bound", 64'(m_acc - start >= 100), 1);

    in_valid = 1;
    out_ready = 0;
    flush = 0;
    tick();
    tick();
    #2;
    rst = 1;
    #1;
    chk("arst_valid", 64'(out_valid), 0);
    chk("arst_ctrl", 64'(out_ctrl), 0);
    chk("arst_pc", 64'(out_pc), 0);
    chk("arst_alu", 64'(out_alu_out), 0);
    chk("arst_cnt", 64'(stall_cnt), 0);
    #2;
    rst = 0;
    in_valid = 0;
    out_ready = 1;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/xm_pipe_stage.md
Name: xm_pipe_stage

Overview:
Parametrised Execute→Memory pipeline register, the successor to the fixed-width XM latch. It adds valid/ready flow control (stall), flush with control-bit kill, and an N-source store-data forwarding mux. It also carries a saturating stall-cycle counter for performance analysis. It sits between the ALU stage and the data-memory/branch-resolve stage.

Parameters:
DATA_W, 32, width of alu_out / store data / forward sources
PC_W, 32, program counter width
RADDR_W, 5, destination register address width
FWD_SRCS, 2, number of store-data forwarding sources (>=1)
CNT_W, 16, stall counter width

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
flush  input  1  kill stage contents (branch mispredict/jump)
in_valid  input  1  upstream (Execute) beat valid
in_ready  output  1  stage can accept a beat
in_ctrl  input  6  {reg_write, read_mem, write_mem, mem_to_reg, branch, jmp}
in_pc  input  PC_W  PC of instruction
in_alu_zero  input  1  ALU zero flag
in_alu_out  input  DATA_W  ALU result
in_write_d  input  DATA_W  store data from register file
in_rd_a  input  RADDR_W  destination register
fwd_sel  input  $clog2(FWD_SRCS+1)  0 = in_write_d, k = fwd_data[k-1]
fwd_data  input  FWD_SRCS*DATA_W  packed forwarding sources, source 0 in LSBs
out_valid  output  1  downstream beat valid
out_ready  input  1  Memory stage accepts beat
out_ctrl  output  6  registered control bundle
out_pc  output  PC_W  registered PC
out_alu_zero  output  1  registered zero flag
out_alu_out  output  DATA_W  registered ALU result
out_write_d  output  DATA_W  registered (possibly forwarded) store data
out_rd_a  output  RADDR_W  registered destination
stall_cnt  output  CNT_W  saturating count of stalled cycles

Behaviour:
- Reset (rst high, async): out_valid=0, out_ctrl=0, out_pc/out_alu_out/out_write_d/out_rd_a/out_alu_zero=0, stall_cnt=0, skid empty. Reset mid-transfer drops the beat; no partial state survives.
- Accept = in_valid && in_ready. Latency 1: an accepted beat appears on out_* the next cycle with out_valid=1.
- Forward mux is evaluated at accept time. fwd_sel=0 or fwd_sel>FWD_SRCS selects in_write_d. Otherwise it selects slice fwd_sel-1. No other field is forwarded.
- Hold: while out_valid && !out_ready, all out_* are stable and unchanged.
- Base mode (macro undefined): in_ready = out_ready || !out_valid (combinational). If out_valid && out_ready && !in_valid, then out_valid→0 next cycle and data regs hold their value (don't-care).
- Flush (sampled at clk edge) has priority over everything. Next cycle: out_valid=0, out_ctrl=0, skid emptied. The incoming beat in that cycle is discarded, and in_ready is unaffected. Flush during a stall clears the held beat.
- out_ctrl is forced to 0 whenever out_valid=0, so a bubble never writes regs or memory.
- stall_cnt increments by 1 in each cycle with out_valid && !out_ready && !flush, and saturates at 2^CNT_W-1. It is not cleared by flush.

Optional Feature:
XM_SKID_EN:
- Defined: a one-entry skid buffer is added and in_ready becomes a register (in_ready = !skid_full), which breaks the out_ready→in_ready combinational path.
  - A beat accepted while the output is stalled goes to the skid.
  - On the next out_ready, the skid drains to the output before any new input; ordering is preserved.
  - Full throughput with no stalls; at most 2 beats in flight.
- Undefined: no skid, combinational in_ready as above, and identical cycle behaviour otherwise.

Decomposition:
- Shared definitions package:
  - XmCtrl packed struct (6 control bits, fixed order above).
  - CTRL_W=6 constant.
  - Existing ProgramCounter/RegAddr typedefs reused when PC_W/RADDR_W are at defaults.
- One sub-module, xm_fwd_mux (combinational FWD_SRCS-way select with out-of-range default). It is reusable by the ID/EX stage.
- Skid logic stays inline under the macro.

Test Plan:
- Reset then single beat (alu_out=0x1234, rd_a=7, ctrl=reg_write, out_ready=1) -> out_valid=1 one cycle later with matching fields; next cycle out_valid=0, out_ctrl=0.
- Forward: FWD_SRCS=2, write_d=0xAAAA, fwd_data={0x2222,0x1111}; fwd_sel=0/1/2/3 -> out_write_d=0xAAAA/0x1111/0x2222/0xAAAA.
- Stall: out_ready=0 for 5 cycles with a valid beat held -> outputs stable, in_ready=0 (base) / in_ready drops after one skid fill (XM_SKID_EN), stall_cnt=5.
- Flush during stall with write_mem=1 held -> next cycle out_valid=0, out_ctrl=0; no memory write is seen by the scoreboard.
- Back-to-back stream of 100 beats with random out_ready -> in-order, lossless, no duplicates; with XM_SKID_EN, full rate when out_ready=1.
- Async reset asserted mid-stream between clock edges -> outputs zero immediately; CNT_W=4 saturation test gives stall_cnt=15 after 20 stalled cycles.
